mips_cpu: RTL and testbench

Multicycle 32-bit MIPS-subset processor core with separate (Harvard) program and data buses. Fetches from an external program memory via `ADDR_Prog`/`CS_P`/`Prog_BUS_READ`, accesses external data memory via `ADDR`/`CS`/`WE`/`Data_BUS_READ`/`Data_BUS_WRITE`, and holds a 32×32 register file internally. It is the top compute block; memories are external.

---
 rtl/mips_cpu.sv | 152 +++++++++++++++
 tb/tb_mips_cpu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu.sv
// Multicycle MIPS-subset core: IDLE/FETCH/DECODE/EXEC/MEM/WB, Harvard buses, 32x32 register file.
// Define CPU_MUL_EN to build the MUL (op 0x1C, funct 0x02) multiplier; otherwise MUL runs as a NOP.
module mips_cpu (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Prog_BUS_READ,
    input  logic [31:0] Data_BUS_READ,
    output logic [31:0] ADDR_Prog,
    output logic        CS_P,
    output logic [31:0] ADDR,
    output logic [31:0] Data_BUS_WRITE,
    output logic        CS,
    output logic        WE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    logic [2:0]         state;
    logic [31:0]        pc, ir, alu_out, mdr;
    logic signed [31:0] a, b, imm_ext;
    logic [31:0]        regs [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] imm26;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];
    assign imm16 = ir[15:0];
    assign imm26 = ir[25:0];

    logic is_alu_r, is_mul, is_addi, is_lw, is_sw, is_beq, is_j;

    // A nonzero shift field makes an R-type word non-canonical, so it is treated as unknown.
    assign is_alu_r = (op == 6'h00) && (shamt == 5'd0) &&
                      ((funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                       (funct == 6'h25) || (funct == 6'h2A));
`ifdef CPU_MUL_EN
    assign is_mul   = (op == 6'h1C) && (shamt == 5'd0) && (funct == 6'h02);
`else
    assign is_mul   = 1'b0;
`endif
    assign is_addi  = (op == 6'h08);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2B);
    assign is_beq   = (op == 6'h04);
    assign is_j     = (op == 6'h02);

    function automatic logic [31:0] alu_r(input logic [5:0] f,
                                          input logic signed [31:0] x,
                                          input logic signed [31:0] y);
        case (f)
            6'h20:   alu_r = x + y;
            6'h22:   alu_r = x - y;
            6'h24:   alu_r = x & y;
            6'h25:   alu_r = x | y;
            6'h2A:   alu_r = {31'b0, (x < y)};
            default: alu_r = '0;
        endcase
    endfunction

    logic [31:0] alu_res;

    always_comb begin
        alu_res = '0;
        if (is_alu_r)
            alu_res = alu_r(funct, a, b);
        if (is_addi || is_lw || is_sw)
            alu_res = a + imm_ext;
`ifdef CPU_MUL_EN
        if (is_mul)
            alu_res = a * b;
`endif
    end

    logic [31:0] rd_rs, rd_rt;

    assign rd_rs = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rd_rt = (rt == 5'd0) ? 32'd0 : regs[rt];

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm_ext <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    ir    <= Prog_BUS_READ;
                    pc    <= pc + 32'd4;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a       <= rd_rs;
                    b       <= rd_rt;
                    imm_ext <= {{16{imm16[15]}}, imm16};
                    state   <= S_EXEC;
                end
                // pc already holds the address of the next sequential instruction here.
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (is_beq && (a == b))
                        pc <= pc + {imm_ext[29:0], 2'b00};
                    else if (is_j)
                        pc <= {pc[31:28], imm26, 2'b00};
                    state <= S_MEM;
                end
                S_MEM: begin
                    if (is_lw)
                        mdr <= Data_BUS_READ;
                    state <= S_WB;
                end
                S_WB: begin
                    if ((is_alu_r || is_mul) && (rd != 5'd0))
                        regs[rd] <= alu_out;
                    else if (is_addi && (rt != 5'd0))
                        regs[rt] <= alu_out;
                    else if (is_lw && (rt != 5'd0))
                        regs[rt] <= mdr;
                    state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ADDR_Prog      = pc;
    assign ADDR           = alu_out;
    assign Data_BUS_WRITE = b;
    assign CS_P           = (state == S_FETCH);
    assign CS             = (state == S_MEM) && (is_lw || is_sw);
    assign WE             = (state == S_MEM) && is_sw;

endmodule

// File: tb/tb_mips_cpu.sv
// Scoreboard bench for mips_cpu: expected fetch addresses and data-bus accesses are queued,
// and a negedge monitor pops and compares them whenever CS_P or CS is presented.
module tb_mips_cpu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] prog_rd, data_rd;
    logic [31:0] addr_prog, addr, wdata;
    logic        cs_p, cs, we;

    always #5 clk = ~clk;

    mips_cpu dut (
        .CLK            (clk),
        .Reset          (rst_n),
        .Prog_BUS_READ  (prog_rd),
        .Data_BUS_READ  (data_rd),
        .ADDR_Prog      (addr_prog),
        .CS_P           (cs_p),
        .ADDR           (addr),
        .Data_BUS_WRITE (wdata),
        .CS             (cs),
        .WE             (we)
    );

    logic [31:0] prog [128];
    assign prog_rd = prog[addr_prog[8:2]];
    assign data_rd = 32'hDEADBEEF;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_t;

    logic [31:0] fetch_q [$];
    mem_t        mem_q   [$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [5:0] funct);
        return {op, rs, rt, rd, 5'd0, funct};
    endfunction

    task automatic exp_mem(input logic w, input logic [31:0] a, input logic [31:0] d);
        mem_t m;
        m.we = w;
        m.addr = a;
        m.data = d;
        mem_q.push_back(m);
    endtask

    // Monitor: fetch gap counts negedges since the previous fetch (2 after reset release).
    initial begin
        int      since;
        bit      first;
        mem_t    m;
        since = 0;
        first = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                since = 0;
                first = 1'b1;
            end else begin
                since++;
                if (cs_p && fetch_q.size() > 0) begin
                    chk("fetch_addr", addr_prog, fetch_q.pop_front());
                    chk("fetch_gap", since, first ? 2 : 5);
                    since = 0;
                    first = 1'b0;
                end
                if (cs) begin
                    if (mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem: addr %h we %b, required no access", addr, we);
                    end else begin
                        m = mem_q.pop_front();
                        chk("mem_we", 32'(we), 32'(m.we));
                        chk("mem_addr", addr, m.addr);
                        if (m.we)
                            chk("mem_wdata", wdata, m.data);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++)
            prog[i] = 32'h0;
        prog[32'h00 >> 2] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);        // ADDI r1,r0,7
        prog[32'h04 >> 2] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);     // ADDI r2,r0,-3
        prog[32'h08 >> 2] = enc_r(6'h00, 5'd1, 5'd2, 5'd3, 6'h20);  // ADD
        prog[32'h0C >> 2] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0080);
        prog[32'h10 >> 2] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);        // BEQ taken
        prog[32'h14 >> 2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h007C);
        prog[32'h18 >> 2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h007C);
        prog[32'h1C >> 2] = enc_r(6'h00, 5'd1, 5'd2, 5'd3, 6'h22);  // SUB
        prog[32'h20 >> 2] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0084);
        prog[32'h24 >> 2] = enc_r(6'h00, 5'd1, 5'd2, 5'd3, 6'h24);  // AND
        prog[32'h28 >> 2] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0088);
        prog[32'h2C >> 2] = enc_r(6'h00, 5'd1, 5'd2, 5'd3, 6'h25);  // OR
        prog[32'h30 >> 2] = enc_i(6'h2B, 5'd0, 5'd3, 16'h008C);
        prog[32'h34 >> 2] = enc_r(6'h00, 5'd1, 5'd2, 5'd3, 6'h2A);  // SLT
        prog[32'h38 >> 2] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0090);
        prog[32'h3C >> 2] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);        // LW r4,8(r0)
        prog[32'h40 >> 2] = enc_i(6'h2B, 5'd0, 5'd4, 16'd16);       // SW r4,16(r0)
        prog[32'h44 >> 2] = enc_i(6'h04, 5'd1, 5'd2, 16'd5);        // BEQ not taken
        prog[32'h48 >> 2] = enc_i(6'h08, 5'd0, 5'd0, 16'd5);        // ADDI r0,r0,5
        prog[32'h4C >> 2] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0094);
        prog[32'h50 >> 2] = 32'hFC000000;                           // unknown opcode 0x3F
        prog[32'h54 >> 2] = enc_i(6'h08, 5'd0, 5'd1, 16'd6);
        prog[32'h58 >> 2] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFF9);
        prog[32'h5C >> 2] = enc_r(6'h1C, 5'd1, 5'd2, 5'd3, 6'h02);  // MUL
        prog[32'h60 >> 2] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0098);
        prog[32'h64 >> 2] = {6'h02, 26'h40};                        // J 0x40
        prog[32'h100 >> 2] = {6'h02, 26'h40};

        foreach (fetch_q[i]) fetch_q.delete(i);
        begin
            logic [31:0] seq [26];
            seq = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h20, 32'h24,
                    32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44,
                    32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h60, 32'h64,
                    32'h100, 32'h100};
            foreach (seq[i]) fetch_q.push_back(seq[i]);
        end
        exp_mem(1'b1, 32'h80, 32'd4);
        exp_mem(1'b1, 32'h84, 32'd10);
        exp_mem(1'b1, 32'h88, 32'd5);
        exp_mem(1'b1, 32'h8C, 32'hFFFFFFFF);
        exp_mem(1'b1, 32'h90, 32'd0);
        exp_mem(1'b0, 32'h08, 32'd0);
        exp_mem(1'b1, 32'h10, 32'hDEADBEEF);
        exp_mem(1'b1, 32'h94, 32'd0);
`ifdef CPU_MUL_EN
        exp_mem(1'b1, 32'h98, 32'hFFFFFFD6);
`else
        exp_mem(1'b1, 32'h98, 32'd0);
`endif

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr_prog", addr_prog, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_cs_p", 32'(cs_p), 32'd0);
        chk("rst_cs", 32'(cs), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 600 && (fetch_q.size() != 0 || mem_q.size() != 0); i++)
            @(posedge clk);
        chk("timeout_fetch_left", fetch_q.size(), 32'd0);
        chk("timeout_mem_left", mem_q.size(), 32'd0);

        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_addr_prog", addr_prog, 32'd0);
        chk("midrst_cs_p", 32'(cs_p), 32'd0);
        chk("midrst_cs", 32'(cs), 32'd0);
        chk("midrst_we", 32'(we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
